dcache_responder: RTL

Responder end of the core's data-memory interface: accepts the one-cycle load/store requests issued from the core's memory-access stage (`dcache_r_ena`/`dcache_w_ena`, `dcache_addr`, `dcache_width`, `dcache_ext`, `dcache_data_in`) and returns `dcache_valid`/`dcache_data_out`. It holds a direct-mapped, one-word-per-line, write-through, write-update cache in front of a single-word request/ready backing-memory port. It performs byte-lane extraction, sign or zero extension, and byte-strobe generation.

---
 rtl/dcache_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, one-word-per-line, write-through,
// write-update data cache sitting between the core's memory-access stage and
// a single-word request/ready backing memory.
// Optional build macro: DCACHE_UNCACHED_IO_EN -- when defined, addresses with
// addr[31:16] == 16'hFFFF bypass the cache (reads always fill from memory
// without allocating, writes never update a line).
module dcache_responder #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_r_ena,
  input  logic        dcache_w_ena,
  input  logic        dcache_ext,
  input  logic [1:0]  dcache_width,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_data_in,
  output logic        dcache_valid,
  output logic [31:0] dcache_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       state_reg;
  logic [LINES-1:0] valid_reg;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Request attributes captured at acceptance; needed once memory answers.
  logic [31:0] addr_reg;
  logic [1:0]  width_reg;
  logic        ext_reg;
  logic        hit_reg;
  logic        uncached_reg;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          req_uncached;
  logic          req_hit;
  logic [IW-1:0] cur_idx;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [31:0]   merged;
  logic          line_we;
  logic [31:0]   line_wdata;

  assign req_idx = dcache_addr[IW+1:2];
  assign req_tag = dcache_addr[31:IW+2];
  assign cur_idx = addr_reg[IW+1:2];

`ifdef DCACHE_UNCACHED_IO_EN
  assign req_uncached = (dcache_addr[31:16] == 16'hFFFF);
`else
  assign req_uncached = 1'b0;
`endif

  assign req_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag) && !req_uncached;

  // Lane-replicated store data and byte strobes for the incoming store.
  always_comb begin
    st_wdata = dcache_data_in;
    st_wstrb = 4'b1111;
    case (dcache_width)
      2'b00: begin
        st_wdata = {4{dcache_data_in[7:0]}};
        st_wstrb = 4'b0001 << dcache_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{dcache_data_in[15:0]}};
        st_wstrb = dcache_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = dcache_data_in;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Write-update merge: strobed bytes come from the outstanding store,
  // the rest from the currently cached word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = mem_wstrb[gi] ? mem_wdata[gi*8 +: 8]
                                               : data_mem[cur_idx][gi*8 +: 8];
    end
  endgenerate

  assign line_we = mem_ready && (((state_reg == S_FILL) && !uncached_reg) ||
                                 ((state_reg == S_WRITE) && hit_reg));
  assign line_wdata = (state_reg == S_FILL) ? mem_rdata : merged;

  // Byte/half selection by lane followed by sign or zero extension.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] width, input logic ext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (width)
      2'b00:   r = {{24{b[7] & ~ext}}, b};
      2'b01:   r = {{16{h[15] & ~ext}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Tag/data storage: no reset, written on fill or on a write-through hit.
  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      tag_mem[cur_idx]  <= addr_reg[31:IW+2];
      data_mem[cur_idx] <= line_wdata;
    end
  end

  // Control FSM, valid bits and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      valid_reg       <= '0;
      addr_reg        <= '0;
      width_reg       <= 2'b00;
      ext_reg         <= 1'b0;
      hit_reg         <= 1'b0;
      uncached_reg    <= 1'b0;
      dcache_valid    <= 1'b0;
      dcache_data_out <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= 4'b0000;
    end else begin
      dcache_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (dcache_w_ena) begin
            state_reg <= S_WRITE;
            addr_reg  <= dcache_addr;
            hit_reg   <= req_hit;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {dcache_addr[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= st_wstrb;
          end else if (dcache_r_ena) begin
            addr_reg     <= dcache_addr;
            width_reg    <= dcache_width;
            ext_reg      <= dcache_ext;
            uncached_reg <= req_uncached;
            if (req_hit) begin
              dcache_valid    <= 1'b1;
              dcache_data_out <= extract(data_mem[req_idx], dcache_addr[1:0],
                                         dcache_width, dcache_ext);
            end else begin
              state_reg <= S_FILL;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {dcache_addr[31:2], 2'b00};
              mem_wstrb <= 4'b0000;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            state_reg       <= S_IDLE;
            mem_req         <= 1'b0;
            dcache_valid    <= 1'b1;
            dcache_data_out <= extract(mem_rdata, addr_reg[1:0], width_reg, ext_reg);
            if (!uncached_reg) valid_reg[cur_idx] <= 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            state_reg    <= S_IDLE;
            mem_req      <= 1'b0;
            dcache_valid <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
